// File: rtl/fft64_pkg.sv
// Shared constants, read-FSM encoding and bit-reverse helper for the fft64
// output reorder buffer.
package fft64_pkg;

    localparam int DW   = 10;
    localparam int N    = 64;
    localparam int LOGN = 6;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rstate_t;

    // Mirror the LOGN address bits: bit 0 becomes the MSB.
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft64_pingpong_ram.sv
// Two-bank sample store: one synchronous write port and one combinational
// read port, both addressed as {bank, slot}. Storage carries no reset; a bank
// is only read after its full flag says every slot was written.
module fft64_pingpong_ram
    import fft64_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [LOGN:0]     waddr,
    input  logic [2*DW-1:0]   wdata,
    input  logic [LOGN:0]     raddr,
    output logic [2*DW-1:0]   rdata
);

    logic [2*DW-1:0] mem [2*N];

    // Capture one {re, im} word per accepted input sample.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft64_out_reorder.sv
// Reorders fft64 bit-reversed output frames into natural bin order. Frames are
// written into ping-pong banks (never stalling the FFT) and replayed over a
// valid/ready port. A frame arriving while no bank is free is dropped whole
// and flagged through the sticky overflow output.
module fft64_out_reorder
    import fft64_pkg::*;
#(
    parameter int BITREV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   din_re,
    input  logic [DW-1:0]   din_im,
    input  logic            din_valid,
    output logic [DW-1:0]   dout_re,
    output logic [DW-1:0]   dout_im,
    output logic [LOGN-1:0] dout_index,
    output logic            dout_last,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            overflow,
    output logic            busy
);

    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic [LOGN-1:0] rcnt_nxt;
    logic [LOGN-1:0] wslot;
    logic            wbank;
    logic            rbank;
    logic            drop;
    logic [1:0]      full;
    rstate_t         rstate;

    logic            frame_start;
    logic            drop_now;
    logic            we;
    logic            wr_last;
    logic            hs;
    logic            rd_last;
    logic [LOGN:0]   waddr;
    logic [LOGN:0]   raddr;
    logic [2*DW-1:0] rdata;

    // The keep/drop decision is made combinationally on the first sample so
    // that sample itself is either stored or discarded with the rest.
    assign frame_start = din_valid && (wcnt == '0);
    assign drop_now    = frame_start ? full[wbank] : drop;
    assign we          = din_valid && !drop_now;
    assign wr_last     = we && (wcnt == LAST);
    assign wslot       = (BITREV != 0) ? bitrev(wcnt) : wcnt;
    assign waddr       = {wbank, wslot};

    assign hs       = dout_valid && dout_ready;
    assign rd_last  = (rstate == R_DRAIN) && hs && (rcnt == LAST);
    assign rcnt_nxt = rcnt + LOGN'(1);

    // Read address points at whatever the output register loads on this edge.
    always_comb begin
        raddr = {rbank, {LOGN{1'b0}}};
        if ((rstate == R_DRAIN) && hs) begin
            if (rcnt != LAST) begin
                raddr = {rbank, rcnt_nxt};
            end else begin
                raddr = {~rbank, {LOGN{1'b0}}};
            end
        end
    end

    fft64_pingpong_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({din_re, din_im}),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Write side: sample counter, bank pointer, drop decision, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else if (din_valid) begin
            wcnt <= wcnt + LOGN'(1);
            if (frame_start) begin
                drop <= full[wbank];
                if (full[wbank]) begin
                    overflow <= 1'b1;
                end
            end
            if (wr_last) begin
                wbank <= ~wbank;
            end
        end
    end

    // Bank full flags: set when a kept frame completes, cleared after its last
    // output handshake. Set and clear always target different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (wr_last) begin
                full[wbank] <= 1'b1;
            end
            if (rd_last) begin
                full[rbank] <= 1'b0;
            end
        end
    end

    // Read FSM: drains full banks in natural order, chaining into the other
    // bank without a bubble when it is already full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate     <= R_IDLE;
            rbank      <= 1'b0;
            rcnt       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (full[rbank]) begin
                        {dout_re, dout_im} <= rdata;
                        dout_valid         <= 1'b1;
                        dout_last          <= 1'b0;
                        rcnt               <= '0;
                        rstate             <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (hs) begin
                        if (rcnt != LAST) begin
                            {dout_re, dout_im} <= rdata;
                            rcnt               <= rcnt_nxt;
                            dout_last          <= (rcnt_nxt == LAST);
                        end else begin
                            rbank     <= ~rbank;
                            rcnt      <= '0;
                            dout_last <= 1'b0;
                            if (full[~rbank]) begin
                                {dout_re, dout_im} <= rdata;
                            end else begin
                                dout_valid <= 1'b0;
                                rstate     <= R_IDLE;
                            end
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign dout_index = rcnt;
    assign busy       = (|full) || (wcnt != '0);

endmodule

// File: tb/tb_fft64_out_reorder.sv
// Scoreboard bench for fft64_out_reorder. Two instances (bit-reversed and
// pass-through) receive identical stimulus; a frame-level model predicts which
// frames survive and the natural-order replay of each.
module tb_fft64_out_reorder;
    import fft64_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   din_re = '0;
    logic [DW-1:0]   din_im = '0;
    logic            din_valid = 1'b0;
    logic            rdy = 1'b0;
    logic [DW-1:0]   o_re   [2];
    logic [DW-1:0]   o_im   [2];
    logic [LOGN-1:0] o_idx  [2];
    logic            o_last [2];
    logic            o_vld  [2];
    logic            o_ovf  [2];
    logic            o_busy [2];

    fft64_out_reorder #(.BITREV(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
        .din_valid(din_valid), .dout_re(o_re[0]), .dout_im(o_im[0]),
        .dout_index(o_idx[0]), .dout_last(o_last[0]), .dout_valid(o_vld[0]),
        .dout_ready(rdy), .overflow(o_ovf[0]), .busy(o_busy[0])
    );

    fft64_out_reorder #(.BITREV(0)) u_nat (
        .clk(clk), .rst_n(rst_n), .din_re(din_re), .din_im(din_im),
        .din_valid(din_valid), .dout_re(o_re[1]), .dout_im(o_im[1]),
        .dout_index(o_idx[1]), .dout_last(o_last[1]), .dout_valid(o_vld[1]),
        .dout_ready(rdy), .overflow(o_ovf[1]), .busy(o_busy[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;

    // Frame-level model state
    int frames_in = 0;
    int frames_out = 0;
    int wcnt_m = 0;
    bit ovf_exp = 1'b0;
    int last_in_cyc = 0;
    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];
    logic [25:0]   exp_q [2][$];
    int            hs_cyc[$];
    logic [DW-1:0] obs [2][$];
    bit            stall [2];
    logic [26:0]   held [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        int x = v;
        for (int b = 0; b < LOGN; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Ready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: rdy = 1'b0;
                1: rdy = 1'b1;
                2: rdy = ~rdy;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Status monitor: overflow and busy right after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    chk("overflow", 32'(o_ovf[i]), 32'(ovf_exp));
                    chk("busy", 32'(o_busy[i]),
                        32'(((frames_in - frames_out) != 0) || (wcnt_m != 0)));
                end
            end
        end
    end

    // Output monitor: scoreboard pops and hold-while-stalled checks
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    stall[i] = 1'b0;
                    exp_q[i].delete();
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (stall[i]) begin
                        chk("hold_valid", 32'(o_vld[i]), 32'd1);
                        chk("hold_data", 32'({o_last[i], o_idx[i], o_re[i], o_im[i]}),
                            32'(held[i]));
                    end
                    if (o_vld[i] && rdy) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output inst=%0d actual idx=%0d re=%0h required none",
                                     i, o_idx[i], o_re[i]);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk("data", 32'({o_idx[i], o_re[i], o_im[i]}), 32'(e));
                            chk("last", 32'(o_last[i]), 32'(e[25:20] == 6'd63));
                            obs[i].push_back(o_re[i]);
                            if (i == 0) begin
                                hs_cyc.push_back(cyc);
                                if (e[25:20] == 6'd63) frames_out++;
                            end
                        end
                    end
                    stall[i] = o_vld[i] && !rdy;
                    held[i]  = {o_last[i], o_idx[i], o_re[i], o_im[i]};
                end
            end
        end
    end

    // Drive one frame from fr_re/fr_im; gap idle cycles after each sample
    task automatic send_frame(input int gap, input bit rgap);
        bit keep = 1'b0;
        int g;
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #2;
            din_re = fr_re[k];
            din_im = fr_im[k];
            din_valid = 1'b1;
            if (k == 0) begin
                keep = ((frames_in - frames_out) < 2);
                if (!keep) ovf_exp = 1'b1;
            end
            wcnt_m = (k == N - 1) ? 0 : k + 1;
            if (k == N - 1) begin
                last_in_cyc = cyc;
                if (keep) begin
                    for (int m = 0; m < N; m++) begin
                        exp_q[0].push_back({6'(m), fr_re[brev(m)], fr_im[brev(m)]});
                        exp_q[1].push_back({6'(m), fr_re[m], fr_im[m]});
                    end
                    frames_in++;
                end
            end
            g = rgap ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(posedge clk);
                #2;
                din_valid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            din_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < 3000), 32'd1);
        idle(3);
    endtask

    task automatic ramp_frame(input int off);
        for (int k = 0; k < N; k++) begin
            fr_re[k] = DW'((k + off) % 1024);
            fr_im[k] = DW'(63 - k);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = DW'($urandom);
            fr_im[k] = DW'($urandom);
        end
    endtask

    task automatic check_ramp_obs(input int base, input string tag);
        chk({tag, "_count"}, 32'(obs[0].size() - base), 32'd64);
        if (obs[0].size() - base >= 64) begin
            chk({tag, "_re0"},  32'(obs[0][base]),      32'd0);
            chk({tag, "_re1"},  32'(obs[0][base + 1]),  32'd32);
            chk({tag, "_re2"},  32'(obs[0][base + 2]),  32'd16);
            chk({tag, "_re63"}, 32'(obs[0][base + 63]), 32'd63);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hb;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_state", 32'({o_vld[i], o_last[i], o_ovf[i], o_busy[i], o_idx[i]}), 32'd0);
            chk("rst_data", 32'({o_re[i], o_im[i]}), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Single frame, ready high
        ready_mode = 1;
        ramp_frame(0);
        base = obs[0].size();
        hb = hs_cyc.size();
        send_frame(0, 1'b0);
        idle(1);
        wait_drain();
        check_ramp_obs(base, "single");
        if (hs_cyc.size() - hb >= 64) begin
            chk("single_latency", 32'(hs_cyc[hb] - last_in_cyc), 32'd2);
            chk("single_span", 32'(hs_cyc[hb + 63] - hs_cyc[hb]), 32'd63);
        end

        // Backpressure with toggling ready
        ready_mode = 2;
        base = obs[0].size();
        send_frame(0, 1'b0);
        idle(1);
        wait_drain();
        check_ramp_obs(base, "bp");

        // Two contiguous frames, no output bubble
        ready_mode = 1;
        hb = hs_cyc.size();
        ramp_frame(0);
        send_frame(0, 1'b0);
        ramp_frame(64);
        send_frame(0, 1'b0);
        idle(1);
        wait_drain();
        chk("b2b_count", 32'(hs_cyc.size() - hb), 32'd128);
        if (hs_cyc.size() - hb >= 128)
            chk("b2b_span", 32'(hs_cyc[hb + 127] - hs_cyc[hb]), 32'd127);

        // Overflow: three frames with ready low
        ready_mode = 0;
        idle(2);
        rand_frame();
        send_frame(0, 1'b0);
        rand_frame();
        send_frame(0, 1'b0);
        chk("ovf_before_f2", 32'(o_ovf[0]), 32'd0);
        rand_frame();
        send_frame(0, 1'b0);
        idle(1);
        #1;
        chk("ovf_after_f2", 32'(o_ovf[0]), 32'd1);
        hb = hs_cyc.size();
        ready_mode = 1;
        wait_drain();
        chk("ovf_drain_count", 32'(hs_cyc.size() - hb), 32'd128);
        #1;
        chk("ovf_end_valid", 32'(o_vld[0] | o_vld[1]), 32'd0);
        chk("ovf_end_busy", 32'(o_busy[0] | o_busy[1]), 32'd0);

        // Gapped input
        ramp_frame(0);
        base = obs[0].size();
        send_frame(2, 1'b0);
        idle(1);
        wait_drain();
        check_ramp_obs(base, "gap");

        // Random data, random gaps and ready
        ready_mode = 3;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(0, 1'b1);
        end
        idle(5);
        ready_mode = 1;
        wait_drain();

        // Reset in the middle of a drain
        rand_frame();
        send_frame(0, 1'b0);
        idle(1);
        t = 0;
        while (t < 200) begin
            @(negedge clk);
            #1;
            if (o_vld[0] && o_idx[0] == 6'd20) break;
            t++;
        end
        chk("reach_idx20", 32'(t < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        frames_in = frames_out;
        wcnt_m = 0;
        ovf_exp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_valid", 32'(o_vld[i]), 32'd0);
            chk("midrst_ovf", 32'(o_ovf[i]), 32'd0);
            chk("midrst_busy", 32'(o_busy[i]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(10);
        chk("post_rst_quiet", 32'(o_vld[0] | o_vld[1]), 32'd0);
        ramp_frame(0);
        base = obs[0].size();
        hb = obs[1].size();
        send_frame(0, 1'b0);
        idle(1);
        wait_drain();
        check_ramp_obs(base, "post_rst");
        chk("nat_count", 32'(obs[1].size() - hb), 32'd64);
        if (obs[1].size() - hb >= 64) begin
            for (int k = 0; k < N; k++) begin
                chk("nat_order", 32'(obs[1][hb + k]), 32'(k));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft64_out_reorder.md
Name: fft64_out_reorder

Overview:
Receive-side companion of the fft64 stimulus sender. Captures the 64-sample result stream from fft64 (dout_re/dout_im/dout_valid) and stores each frame into one of two ping-pong banks at bit-reversed addresses. Replays each completed frame in natural frequency order over a valid/ready interface to a downstream consumer: checker, file dumper or magnitude stage.
fft64 has no backpressure, so the write side never stalls. When no bank is free, the whole incoming frame is dropped and flagged.

Parameters:
DW, 10, sample width per component (re, im)
N, 64, frame length in samples
LOGN, 6, log2(N)
BITREV, 1, 1 = write address is bit-reverse(write count); 0 = pass-through order

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_re  in  DW  real sample from fft64 dout_re
din_im  in  DW  imaginary sample from fft64 dout_im
din_valid  in  1  sample strobe from fft64 dout_valid
dout_re  out  DW  reordered real sample
dout_im  out  DW  reordered imaginary sample
dout_index  out  LOGN  natural-order bin index of current output
dout_last  out  1  high with index N-1
dout_valid  out  1  output sample valid
dout_ready  in  1  consumer accepts when valid&ready
overflow  out  1  sticky: a frame was dropped
busy  out  1  any bank full or a frame partially written

Behaviour:
- Reset: already decided. Reset rst_n, asynchronous, active-low; clock clk.
  - All outputs 0.
  - Both banks empty.
  - wbank=rbank=0, wcnt=rcnt=0, drop=0, read FSM in R_IDLE.
- Storage:
  - 2 banks x N entries x 2*DW bits, register array with combinational read.
  - Per-bank full flag.
- Write side (counter wcnt, bank pointer wbank, drop flag):
  - wcnt advances only on din_valid; gaps inside a frame are legal.
  - Frame start, din_valid with wcnt==0:
    - If full[wbank]=1: drop<=1, overflow<=1.
    - Else: drop<=0.
    - This decision is evaluated in the same cycle as the first sample.
  - Each din_valid with !drop: write {re,im} to bank[wbank][BITREV ? bitrev(wcnt) : wcnt].
  - On din_valid with wcnt==N-1:
    - wcnt<=0.
    - If not dropping: full[wbank]<=1, wbank toggles.
    - A dropped frame does not toggle wbank.
  - wcnt wraps 63->0 naturally (LOGN bits).
- Read FSM, states R_IDLE and R_DRAIN:
  - R_IDLE, full[rbank]=1: load output register with bank[rbank][0], dout_valid<=1, index 0, go R_DRAIN.
  - R_DRAIN, handshake (valid&ready) with rcnt<N-1: rcnt++, load next entry. Data is never changed while valid&!ready.
  - R_DRAIN, handshake with rcnt==N-1:
    - full[rbank]<=0, rbank toggles, rcnt<=0.
    - If the other bank is already full: load its entry 0 in the same edge, stay R_DRAIN. No bubble.
    - Else: dout_valid<=0, go R_IDLE.
- Latency: last input sample sampled at edge E -> dout_valid=1 with index 0 after edge E+1.
  - With ready held high: N outputs on consecutive cycles, dout_last on the Nth.
- Simultaneous events:
  - Read-side clear of full[x] and write-side frame-start check of bank x in the same cycle: the check sees the old value (full) and drops the frame. Conservative; must be reproducible.
  - Write-side set of full and read-side test are independent banks by construction.
- Sticky flag: overflow is cleared only by reset.
- Reset mid-operation: everything returns to reset state immediately, including dout_valid=0. A partial frame is lost. Writing resumes at the next din_valid as wcnt=0.
- busy = full[0] | full[1] | (wcnt!=0).

Decomposition:
- Shared package fft64_pkg: DW, N, LOGN, bitrev function (LOGN-bit reverse), R_IDLE/R_DRAIN encodings.
- One sub-module: fft64_pingpong_ram. Dual-bank register array, one write port and one combinational read port, addressed by {bank, addr}.
- FSMs and counters stay in the top.

Test Plan:
- Single frame: input re=k, im=63-k for k=0..63, ready=1.
  - Expected: dout_valid rises 1 cycle after last input.
  - index 0 re=0; index 1 re=32, im=31; index 2 re=16; index 63 re=63 with dout_last=1.
  - Exactly 64 outputs.
- Backpressure: same frame, ready toggling 1,0,1,0.
  - Expected: 64 distinct handshakes in correct order.
  - dout_re/dout_im/dout_index stable while valid&!ready.
- Back-to-back: two contiguous frames (frame 1 re=k+64 mod 1024), ready=1.
  - Expected: 128 consecutive outputs with no dout_valid gap between frame 0 index 63 and frame 1 index 0.
- Overflow: ready=0, three contiguous frames.
  - Expected: overflow=1 from the first sample of frame 2.
  - Releasing ready yields frames 0 and 1 only (128 outputs), then dout_valid=0, busy=0.
- Gapped input: din_valid high every third cycle for one frame.
  - Expected: identical output to the single-frame test.
- Reset mid-drain: rst_n low while index=20.
  - Expected: dout_valid=0 immediately, overflow=0, no output after release until a new full frame arrives; that frame then reorders correctly.
  - Repeat the sequence with BITREV=0 and check that index k returns re=k.
